// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and capture stages.
// State encoding and default counter sizing live here so both stages agree.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } pwm_state_t;

    localparam int PWM_CNT_W   = 16;
    localparam int PWM_TIMEOUT = 65535;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchroniser, optional run-length glitch filter and registered rise/fall detect.
// The filter is compiled in only when PWM_CAPTURE_GLITCH_FILT_EN is defined.
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s;
    logic                   src;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILT_EN
    localparam int RUN_W = $clog2(FILT_LEN + 1);

    logic [RUN_W-1:0] run_q;
    logic             filt_q;

    // The filtered level flips only after FILT_LEN consecutive samples disagree with it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q  <= '0;
            filt_q <= 1'b0;
        end else if (pwm_s == filt_q) begin
            run_q <= '0;
        end else if (run_q == RUN_W'(FILT_LEN - 1)) begin
            run_q  <= '0;
            filt_q <= pwm_s;
        end else begin
            run_q <= run_q + RUN_W'(1);
        end
    end

    assign src = filt_q;
`else
    assign src = pwm_s;

    // FILT_LEN only shapes the filter; referenced here so the unfiltered build uses it too
    if (FILT_LEN < 2) begin : g_filt_len_unused
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= src;
            rise_q <= src & ~prev_q;
            fall_q <= ~src & prev_q;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM line, with a dead-line timeout.
// Define PWM_CAPTURE_GLITCH_FILT_EN to insert the run-length glitch filter before edge detect.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int TIMEOUT     = PWM_TIMEOUT,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_count,
    output logic [CNT_W-1:0] high_count,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic             level;
    logic             rise;
    logic             fall;
    pwm_state_t       state;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] hi_hold;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_edge (
        .clock  (clock),
        .reset  (reset),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    // A result is only published on a rise seen from LOW, so the period that
    // started in ARM is the first one ever reported.  A rise always beats a
    // timeout landing on the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            hi_cnt       <= '0;
            hi_hold      <= '0;
            period_count <= '0;
            high_count   <= '0;
            meas_valid   <= 1'b0;
            timeout      <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                cyc_cnt <= '0;
                hi_cnt  <= '0;
                hi_hold <= '0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARM;
                    ARM, HIGH, LOW: begin
                        if (rise) begin
                            state   <= HIGH;
                            cyc_cnt <= CNT_W'(1);
                            hi_cnt  <= CNT_W'(1);
                            if (state == LOW) begin
                                period_count <= cyc_cnt;
                                high_count   <= hi_hold;
                                meas_valid   <= 1'b1;
                                timeout      <= 1'b0;
                            end
                        end else if (cyc_cnt == TIMEOUT_CNT) begin
                            state       <= ARM;
                            cyc_cnt     <= '0;
                            hi_cnt      <= '0;
                            timeout     <= 1'b1;
                            stuck_level <= level;
                        end else begin
                            cyc_cnt <= sat_inc(cyc_cnt);
                            if (state == HIGH) begin
                                if (fall) begin
                                    hi_hold <= hi_cnt;
                                    state   <= LOW;
                                end else begin
                                    hi_cnt <= sat_inc(hi_cnt);
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
